// File: rtl/id_ex_stage.sv
// Decode-to-execute pipeline register with same-cycle writeback bypass, load-use bubble
// insertion and flush. Define ID_EX_STALL_CNT_EN to add the stall_cnt hazard counter output.

module id_ex_opnd_sel #(
    parameter int XLEN = 32
) (
    input  logic [4:0]      rs,
    input  logic [XLEN-1:0] rf_val,
    input  logic            wb_en,
    input  logic [4:0]      wb_rd,
    input  logic [XLEN-1:0] wb_data,
    output logic [XLEN-1:0] val
);
    // rs != 0 already excludes a write to x0 from matching.
    always_comb begin
        val = rf_val;
        if (rs == 5'd0)
            val = '0;
        else if (wb_en && (wb_rd == rs))
            val = wb_data;
    end
endmodule

module id_ex_stage #(
    parameter int XLEN    = 32,
    parameter int ALUOP_W = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [XLEN-1:0]    opa_in,
    input  logic [XLEN-1:0]    opb_in,
    input  logic [4:0]         rs1_in,
    input  logic [4:0]         rs2_in,
    input  logic [4:0]         rd_in,
    input  logic               use_rs1,
    input  logic               use_rs2,
    input  logic [XLEN-1:0]    imm_in,
    input  logic [XLEN-1:0]    pc_in,
    input  logic [ALUOP_W-1:0] alu_op_in,
    input  logic               alu_src_imm_in,
    input  logic               mem_rd_in,
    input  logic               mem_wr_in,
    input  logic               reg_wr_in,
    input  logic               wb_en,
    input  logic [4:0]         wb_rd,
    input  logic [XLEN-1:0]    wb_data,
    input  logic               flush,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [XLEN-1:0]    opa,
    output logic [XLEN-1:0]    opb,
    output logic [XLEN-1:0]    imm,
    output logic [XLEN-1:0]    pc,
    output logic [4:0]         rd,
    output logic [ALUOP_W-1:0] alu_op,
    output logic               alu_src_imm,
    output logic               mem_rd,
    output logic               mem_wr,
    output logic               reg_wr
`ifdef ID_EX_STALL_CNT_EN
    ,
    output logic [31:0]        stall_cnt
`endif
);

    typedef struct packed {
        logic [XLEN-1:0]    opa;
        logic [XLEN-1:0]    opb;
        logic [XLEN-1:0]    imm;
        logic [XLEN-1:0]    pc;
        logic [4:0]         rd;
        logic [ALUOP_W-1:0] alu_op;
        logic               alu_src_imm;
        logic               mem_rd;
        logic               mem_wr;
        logic               reg_wr;
    } payload_t;

    payload_t pay_q, pay_d;
    logic     valid_q, valid_d;
    logic     hazard, fire;

    logic [1:0][4:0]      src_rs;
    logic [1:0][XLEN-1:0] src_rf;
    logic [1:0][XLEN-1:0] src_val;

    assign src_rs = {rs2_in, rs1_in};
    assign src_rf = {opb_in, opa_in};

    for (genvar s = 0; s < 2; s++) begin : g_src
        id_ex_opnd_sel #(.XLEN(XLEN)) u_sel (
            .rs      (src_rs[s]),
            .rf_val  (src_rf[s]),
            .wb_en   (wb_en),
            .wb_rd   (wb_rd),
            .wb_data (wb_data),
            .val     (src_val[s])
        );
    end

    // A held load whose destination the incoming instruction reads cannot forward in time.
    assign hazard = valid_q && pay_q.mem_rd && pay_q.reg_wr && (pay_q.rd != 5'd0) &&
                    ((use_rs1 && (rs1_in == pay_q.rd)) || (use_rs2 && (rs2_in == pay_q.rd)));
    assign in_ready = !rst && !flush && !hazard && (!valid_q || out_ready);
    assign fire     = in_valid && in_ready;

    always_comb begin
        valid_d = valid_q;
        pay_d   = pay_q;
        if (flush) begin
            valid_d = 1'b0;
        end else if (fire) begin
            valid_d           = 1'b1;
            pay_d.opa         = src_val[0];
            pay_d.opb         = src_val[1];
            pay_d.imm         = imm_in;
            pay_d.pc          = pc_in;
            pay_d.rd          = rd_in;
            pay_d.alu_op      = alu_op_in;
            pay_d.alu_src_imm = alu_src_imm_in;
            pay_d.mem_rd      = mem_rd_in;
            pay_d.mem_wr      = mem_wr_in;
            pay_d.reg_wr      = reg_wr_in;
        end else if (!valid_q || out_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
            pay_q   <= '0;
        end else begin
            valid_q <= valid_d;
            pay_q   <= pay_d;
        end
    end

    assign out_valid   = valid_q;
    assign opa         = pay_q.opa;
    assign opb         = pay_q.opb;
    assign imm         = pay_q.imm;
    assign pc          = pay_q.pc;
    assign rd          = pay_q.rd;
    assign alu_op      = pay_q.alu_op;
    assign alu_src_imm = pay_q.alu_src_imm;
    assign mem_rd      = pay_q.mem_rd;
    assign mem_wr      = pay_q.mem_wr;
    assign reg_wr      = pay_q.reg_wr;

`ifdef ID_EX_STALL_CNT_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;

    // Stalls dropped by a flush are not real stalls and are not counted.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (in_valid && hazard && !flush)
            stall_cnt_d = stall_cnt_q + 32'd1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) stall_cnt_q <= '0;
        else     stall_cnt_q <= stall_cnt_d;
    end

    assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: directed steps from the test plan, then random traffic
// against a reference model of the held instruction.

module tb_id_ex_stage;
    localparam int XLEN = 32;
    localparam int AW   = 4;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            in_valid, in_ready;
    logic [XLEN-1:0] opa_in, opb_in, imm_in, pc_in, wb_data;
    logic [4:0]      rs1_in, rs2_in, rd_in, wb_rd;
    logic            use_rs1, use_rs2;
    logic [AW-1:0]   alu_op_in;
    logic            alu_src_imm_in, mem_rd_in, mem_wr_in, reg_wr_in;
    logic            wb_en, flush, out_valid, out_ready;
    logic [XLEN-1:0] opa, opb, imm, pc;
    logic [4:0]      rd;
    logic [AW-1:0]   alu_op;
    logic            alu_src_imm, mem_rd, mem_wr, reg_wr;
`ifdef ID_EX_STALL_CNT_EN
    logic [31:0]     stall_cnt;
`endif

    always #5 clk = ~clk;

    id_ex_stage #(.XLEN(XLEN), .ALUOP_W(AW)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .opa_in(opa_in), .opb_in(opb_in), .rs1_in(rs1_in), .rs2_in(rs2_in), .rd_in(rd_in),
        .use_rs1(use_rs1), .use_rs2(use_rs2), .imm_in(imm_in), .pc_in(pc_in),
        .alu_op_in(alu_op_in), .alu_src_imm_in(alu_src_imm_in), .mem_rd_in(mem_rd_in),
        .mem_wr_in(mem_wr_in), .reg_wr_in(reg_wr_in), .wb_en(wb_en), .wb_rd(wb_rd),
        .wb_data(wb_data), .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
        .opa(opa), .opb(opb), .imm(imm), .pc(pc), .rd(rd), .alu_op(alu_op),
        .alu_src_imm(alu_src_imm), .mem_rd(mem_rd), .mem_wr(mem_wr), .reg_wr(reg_wr)
`ifdef ID_EX_STALL_CNT_EN
        , .stall_cnt(stall_cnt)
`endif
    );

    typedef struct {
        logic            v;
        logic [XLEN-1:0] opa, opb, imm, pc;
        logic [4:0]      rd;
        logic [AW-1:0]   alu_op;
        logic            src, mrd, mwr, rwr;
    } held_t;

    held_t       m;
    int unsigned m_stall;
    int unsigned total = 0, passed = 0, fails = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Architectural value the instruction should see: x0 is zero, a same-cycle write wins.
    function automatic logic [XLEN-1:0] opnd(input logic [4:0] rs, input logic [XLEN-1:0] rf);
        if (rs == 5'd0) return '0;
        if (wb_en && wb_rd == rs) return wb_data;
        return rf;
    endfunction

    function automatic logic m_hazard();
        return m.v && m.mrd && m.rwr && (m.rd != 5'd0) &&
               ((use_rs1 && rs1_in == m.rd) || (use_rs2 && rs2_in == m.rd));
    endfunction

    task automatic check_outs(input string t);
        chk({t, ".out_valid"}, out_valid, m.v);
        chk({t, ".opa"}, opa, m.opa);
        chk({t, ".opb"}, opb, m.opb);
        chk({t, ".imm"}, imm, m.imm);
        chk({t, ".pc"}, pc, m.pc);
        chk({t, ".rd"}, rd, m.rd);
        chk({t, ".alu_op"}, alu_op, m.alu_op);
        chk({t, ".alu_src_imm"}, alu_src_imm, m.src);
        chk({t, ".mem_rd"}, mem_rd, m.mrd);
        chk({t, ".mem_wr"}, mem_wr, m.mwr);
        chk({t, ".reg_wr"}, reg_wr, m.rwr);
`ifdef ID_EX_STALL_CNT_EN
        chk({t, ".stall_cnt"}, stall_cnt, m_stall);
`endif
    endtask

    // Called just after a falling edge with inputs already driven; returns after the next one.
    task automatic cycle();
        held_t nm;
        logic  hz, er;
        #1;
        hz = m_hazard();
        er = !rst && !flush && !hz && (!m.v || out_ready);
        chk("in_ready", in_ready, er);
        nm = m;
        if (flush) nm.v = 1'b0;
        else if (in_valid && er) begin
            nm.v = 1'b1; nm.opa = opnd(rs1_in, opa_in); nm.opb = opnd(rs2_in, opb_in);
            nm.imm = imm_in; nm.pc = pc_in; nm.rd = rd_in; nm.alu_op = alu_op_in;
            nm.src = alu_src_imm_in; nm.mrd = mem_rd_in; nm.mwr = mem_wr_in; nm.rwr = reg_wr_in;
        end else if (!m.v || out_ready) nm.v = 1'b0;
        if (in_valid && hz && !flush) m_stall++;
        @(posedge clk);
        m = nm;
        @(negedge clk);
        check_outs("cyc");
    endtask

    task automatic idle();
        in_valid = 0; opa_in = '0; opb_in = '0; imm_in = '0; pc_in = '0; wb_data = '0;
        rs1_in = '0; rs2_in = '0; rd_in = '0; wb_rd = '0; use_rs1 = 0; use_rs2 = 0;
        alu_op_in = '0; alu_src_imm_in = 0; mem_rd_in = 0; mem_wr_in = 0; reg_wr_in = 0;
        wb_en = 0; flush = 0; out_ready = 1;
    endtask

    task automatic do_reset();
        idle();
        rst = 1;
        m = '{default: 0};
        m_stall = 0;
        @(negedge clk);
        #1;
        chk("rst.in_ready", in_ready, 0);
        check_outs("rst");
        rst = 0;
        cycle();
    endtask

    task automatic load_issue();
        idle();
        in_valid = 1; rs1_in = 5'd1; rs2_in = 5'd2; rd_in = 5'd7;
        mem_rd_in = 1; reg_wr_in = 1; pc_in = 32'h180;
        cycle();
        mem_rd_in = 0; rd_in = 5'd8; use_rs1 = 1; rs1_in = 5'd7; pc_in = 32'h200;
    endtask

    task automatic load_use();
        load_issue();
        cycle();
        chk("lu.bubble", out_valid, 0);
        cycle();
        chk("lu.accept", out_valid, 1);
        idle();
        cycle();
    endtask

    initial begin
        idle();
        in_valid = 1;
        m = '{default: 0};
        m_stall = 0;
        repeat (2) @(negedge clk);
        #1;
        chk("rst.in_ready", in_ready, 0);
        check_outs("rst");
        idle();
        rst = 0;
        cycle();

        // pass-through
        in_valid = 1; rs1_in = 5'd3; opa_in = 32'h11; rs2_in = 5'd4; opb_in = 32'h22;
        use_rs1 = 1; use_rs2 = 1; pc_in = 32'h100; imm_in = 32'h5;
        cycle();
        chk("pt.out_valid", out_valid, 1);
        chk("pt.opa", opa, 32'h11);
        chk("pt.opb", opb, 32'h22);

        // x0 and bypass
        rs1_in = 5'd0; opa_in = 32'hDEAD; rs2_in = 5'd5; opb_in = 32'h1;
        wb_en = 1; wb_rd = 5'd5; wb_data = 32'hCAFE;
        cycle();
        chk("x0.opa", opa, 32'h0);
        chk("byp.opb", opb, 32'hCAFE);
        wb_rd = 5'd0; opb_in = 32'h55;
        cycle();
        chk("nobyp.opb", opb, 32'h55);

        // load-use: one bubble, then the consumer picks up the loaded value via writeback
        load_issue();
        #1 chk("lu.in_ready", in_ready, 0);
        cycle();
        chk("lu.bubble", out_valid, 0);
        wb_en = 1; wb_rd = 5'd7; wb_data = 32'h77; opa_in = 32'h0;
        cycle();
        chk("lu.accept", out_valid, 1);
        chk("lu.fwd", opa, 32'h77);
        chk("lu.pc", pc, 32'h200);

        // same shape without use_rs1: no stall
        load_issue();
        use_rs1 = 0; pc_in = 32'h280;
        #1 chk("nolu.in_ready", in_ready, 1);
        cycle();
        chk("nolu.pc", pc, 32'h280);

        // backpressure for 3 cycles, then exactly one capture
        in_valid = 1; out_ready = 0;
        for (int i = 0; i < 3; i++) begin
            pc_in = 32'h300 + 32'(4 * i);
            cycle();
            chk("bp.hold_pc", pc, 32'h280);
            chk("bp.hold_valid", out_valid, 1);
        end
        out_ready = 1; pc_in = 32'h30C;
        cycle();
        chk("bp.release_pc", pc, 32'h30C);
        in_valid = 0;
        cycle();
        chk("bp.no_dup", out_valid, 0);

        // flush drops incoming and invalidates held; data holds
        in_valid = 1; pc_in = 32'h400;
        cycle();
        flush = 1; pc_in = 32'h500;
        cycle();
        chk("fl.valid", out_valid, 0);
        chk("fl.pc_hold", pc, 32'h400);
        flush = 0;

        // flush during a hazard: dropped, not counted
        load_issue();
        flush = 1;
        cycle();
        chk("flhz.valid", out_valid, 0);
`ifdef ID_EX_STALL_CNT_EN
        chk("flhz.stall_cnt", stall_cnt, 32'd1);
`endif

        // three separate load-use hazards
        do_reset();
        for (int i = 0; i < 3; i++) load_use();
`ifdef ID_EX_STALL_CNT_EN
        chk("cnt3", stall_cnt, 32'd3);
`endif

        // reset in the middle of a stall
        do_reset();
        for (int i = 0; i < 2; i++) load_use();
        load_issue();
        #2 rst = 1;
        #1;
        chk("rstmid.valid", out_valid, 0);
        chk("rstmid.in_ready", in_ready, 0);
`ifdef ID_EX_STALL_CNT_EN
        chk("rstmid.stall_cnt", stall_cnt, 32'd0);
`endif
        m = '{default: 0};
        m_stall = 0;
        idle();
        @(negedge clk);
        rst = 0;
        cycle();

        // random traffic with small register indices so hazards and bypasses are frequent
        for (int n = 0; n < 500; n++) begin
            in_valid = ($urandom_range(0, 3) != 0);
            rs1_in = 5'($urandom_range(0, 7)); rs2_in = 5'($urandom_range(0, 7));
            rd_in = 5'($urandom_range(0, 7));
            use_rs1 = 1'($urandom); use_rs2 = 1'($urandom);
            opa_in = $urandom; opb_in = $urandom; imm_in = $urandom; pc_in = $urandom;
            alu_op_in = 4'($urandom); alu_src_imm_in = 1'($urandom);
            mem_rd_in = ($urandom_range(0, 2) == 0); mem_wr_in = 1'($urandom);
            reg_wr_in = ($urandom_range(0, 3) != 0);
            wb_en = 1'($urandom); wb_rd = 5'($urandom_range(0, 7)); wb_data = $urandom;
            flush = ($urandom_range(0, 9) == 0);
            out_ready = ($urandom_range(0, 9) < 7);
            cycle();
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
